// File: rtl/cory_rr_arb_if.sv
// Valid-ready fan-in bundle for cory_rr_arb: N requester channels in, one merged channel out.
// The slave modport is the arbiter side; the master modport drives requesters and downstream ready.
interface cory_rr_arb_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = 2
);
   logic [N-1:0]   i_ax_v;
   logic [N*W-1:0] i_ax_d;
   logic [N-1:0]   i_ax_last;
   logic [N-1:0]   o_ax_r;
   logic           o_z_v;
   logic [W-1:0]   o_z_d;
   logic [IW-1:0]  o_z_id;
   logic           i_z_r;

   modport master (
      output i_ax_v, i_ax_d, i_ax_last, i_z_r,
      input  o_ax_r, o_z_v, o_z_d, o_z_id
   );

   modport slave (
      input  i_ax_v, i_ax_d, i_ax_last, i_z_r,
      output o_ax_r, o_z_v, o_z_d, o_z_id
   );
endinterface

// File: rtl/cory_rr_arb.sv
// Zero-latency round-robin arbiter merging N valid-ready requesters onto one output channel.
// Define CORY_ARB_PKT_EN to lock the grant for a whole packet (until i_ax_last on a handshake).
//
// state | meaning
// IDLE  | grant chosen combinationally by round-robin scan from ptr
// HOLD  | offer stalled by downstream; grant frozen in gnt_q until handshake
// PKT   | (CORY_ARB_PKT_EN only) mid-packet; grant locked in gnt_q until last beat
module cory_rr_arb #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = 2
) (
   input  logic              clk,
   input  logic              reset,
   cory_rr_arb_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      PKT  = 2'd2
   } state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] gnt_q;

   logic [IW-1:0] sel;
   logic          any_v;
   logic [IW-1:0] gnt;
   logic          v_g;
   logic [W-1:0]  d_g;
   logic          z_v;
   logic          hs;
   logic [IW-1:0] nxt_ptr;
   int            idx;

   // Scan ptr, ptr+1, ... wrapping at N, not at 2**IW
   always_comb begin
      sel   = ptr;
      any_v = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!any_v && bus.i_ax_v[idx]) begin
            sel   = IW'(idx);
            any_v = 1'b1;
         end
      end
   end

   always_comb begin
      gnt = (state == IDLE) ? sel : gnt_q;
      v_g = 1'b0;
      d_g = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt == IW'(k)) begin
            v_g = bus.i_ax_v[k];
            d_g = bus.i_ax_d[k*W +: W];
         end
      end
   end

   assign z_v        = v_g & ~reset;
   assign hs         = z_v & bus.i_z_r;
   assign nxt_ptr    = (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
   assign bus.o_z_v  = z_v;
   assign bus.o_z_id = reset ? '0 : gnt;
   assign bus.o_z_d  = (reset || (state == IDLE && !any_v)) ? '0 : d_g;

   always_comb begin
      bus.o_ax_r = '0;
      for (int k = 0; k < N; k++) begin
         bus.o_ax_r[k] = bus.i_z_r & (gnt == IW'(k)) & z_v;
      end
   end

`ifdef CORY_ARB_PKT_EN
   logic last_g;

   always_comb begin
      last_g = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (gnt == IW'(k)) last_g = bus.i_ax_last[k];
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         gnt_q <= '0;
      end else if (hs) begin
`ifdef CORY_ARB_PKT_EN
         if (!last_g) begin
            gnt_q <= gnt;
            state <= PKT;
         end else begin
            ptr   <= nxt_ptr;
            state <= IDLE;
         end
`else
         ptr   <= nxt_ptr;
         state <= IDLE;
`endif
      end else if (state == IDLE && z_v) begin
         gnt_q <= gnt;
         state <= HOLD;
      end
   end

`ifdef SIM
   always_ff @(posedge clk) begin
      if (!reset && state != IDLE && !v_g)
         $display("ERROR cory_rr_arb: requester %0d dropped valid while granted", gnt);
   end
`endif

endmodule

// File: tb/tb_cory_rr_arb.sv
// Directed bench for cory_rr_arb (N=4 and N=3 instances) with a queue-based expectation scoreboard.
module tb_cory_rr_arb;

   logic clk;
   logic reset;
   logic reset3;

   int vectors;
   int miscompares;

   typedef struct {
      logic       zv;
      logic [1:0] id;
      logic [3:0] ar;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];

   cory_rr_arb_if #(.N(4), .W(8), .IW(2)) if4 ();
   cory_rr_arb_if #(.N(3), .W(8), .IW(2)) if3 ();

   cory_rr_arb #(.N(4), .W(8), .IW(2)) dut4 (.clk(clk), .reset(reset),  .bus(if4));
   cory_rr_arb #(.N(3), .W(8), .IW(2)) dut3 (.clk(clk), .reset(reset3), .bus(if3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step4(input logic rst, input logic [3:0] v, input logic zr, input logic [3:0] last,
                        input logic ezv, input logic [1:0] eid, input logic [3:0] ear, input logic [7:0] ed);
      exp_t e;
      @(negedge clk);
      reset         = rst;
      if4.i_ax_v    = v;
      if4.i_z_r     = zr;
      if4.i_ax_last = last;
      sb.push_back('{zv: ezv, id: eid, ar: ear, d: ed});
      #2;
      e = sb.pop_front();
      chk("n4_z_v",  32'(if4.o_z_v),  32'(e.zv));
      chk("n4_z_id", 32'(if4.o_z_id), 32'(e.id));
      chk("n4_ax_r", 32'(if4.o_ax_r), 32'(e.ar));
      chk("n4_z_d",  32'(if4.o_z_d),  32'(e.d));
   endtask

   task automatic step3(input logic rst, input logic [2:0] v, input logic zr,
                        input logic ezv, input logic [1:0] eid, input logic [2:0] ear, input logic [7:0] ed);
      exp_t e;
      @(negedge clk);
      reset3     = rst;
      if3.i_ax_v = v;
      if3.i_z_r  = zr;
      sb.push_back('{zv: ezv, id: eid, ar: {1'b0, ear}, d: ed});
      #2;
      e = sb.pop_front();
      chk("n3_z_v",  32'(if3.o_z_v),  32'(e.zv));
      chk("n3_z_id", 32'(if3.o_z_id), 32'(e.id));
      chk("n3_ax_r", 32'(if3.o_ax_r), 32'(e.ar[2:0]));
      chk("n3_z_d",  32'(if3.o_z_d),  32'(e.d));
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset         = 1'b1;
      reset3        = 1'b1;
      if4.i_ax_v    = '0;
      if4.i_ax_d    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      if4.i_ax_last = '1;
      if4.i_z_r     = 1'b0;
      if3.i_ax_v    = '0;
      if3.i_ax_d    = {8'hB2, 8'hB1, 8'hB0};
      if3.i_ax_last = '1;
      if3.i_z_r     = 1'b0;

      // reset holds outputs quiet even with all requesters valid
      step4(1, 4'b1111, 1, 4'b1111, 0, 0, 4'b0000, 8'h00);
      // fairness with everyone valid
      step4(0, 4'b1111, 1, 4'b1111, 1, 0, 4'b0001, 8'hA0);
      step4(0, 4'b1111, 1, 4'b1111, 1, 1, 4'b0010, 8'hA1);
      step4(0, 4'b1111, 1, 4'b1111, 1, 2, 4'b0100, 8'hA2);
      step4(0, 4'b1111, 1, 4'b1111, 1, 3, 4'b1000, 8'hA3);
      step4(0, 4'b1111, 1, 4'b1111, 1, 0, 4'b0001, 8'hA0);

      // stall on requester 1 for three cycles, then accept; 2 next
      step4(1, 4'b0000, 0, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b0110, 0, 4'b1111, 1, 1, 4'b0000, 8'hA1);
      step4(0, 4'b0110, 0, 4'b1111, 1, 1, 4'b0000, 8'hA1);
      step4(0, 4'b0110, 0, 4'b1111, 1, 1, 4'b0000, 8'hA1);
      step4(0, 4'b0110, 1, 4'b1111, 1, 1, 4'b0010, 8'hA1);
      step4(0, 4'b0101, 1, 4'b1111, 1, 2, 4'b0100, 8'hA2);
      step4(0, 4'b0001, 1, 4'b1111, 1, 0, 4'b0001, 8'hA0);

      // held grant on 2 ignores a new request from 0
      step4(0, 4'b0100, 0, 4'b1111, 1, 2, 4'b0000, 8'hA2);
      step4(0, 4'b0101, 0, 4'b1111, 1, 2, 4'b0000, 8'hA2);
      step4(0, 4'b0101, 1, 4'b1111, 1, 2, 4'b0100, 8'hA2);
      step4(0, 4'b0001, 1, 4'b1111, 1, 0, 4'b0001, 8'hA0);

      // reset in HOLD discards the pending grant
      step4(0, 4'b0010, 0, 4'b1111, 1, 1, 4'b0000, 8'hA1);
      step4(1, 4'b0010, 0, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b1000, 0, 4'b1111, 1, 3, 4'b0000, 8'hA3);
      step4(0, 4'b1000, 1, 4'b1111, 1, 3, 4'b1000, 8'hA3);

      // ready toggling with nothing valid leaves ptr alone
      step4(0, 4'b0000, 1, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b0000, 0, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b0000, 1, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b0010, 1, 4'b1111, 1, 1, 4'b0010, 8'hA1);

      // requester 1 sends a 3-beat packet while requester 0 stays valid
      step4(1, 4'b0000, 0, 4'b1111, 0, 0, 4'b0000, 8'h00);
      step4(0, 4'b0011, 1, 4'b0001, 1, 0, 4'b0001, 8'hA0);
      step4(0, 4'b0011, 1, 4'b0001, 1, 1, 4'b0010, 8'hA1);
`ifdef CORY_ARB_PKT_EN
      step4(0, 4'b0011, 1, 4'b0001, 1, 1, 4'b0010, 8'hA1);
`else
      step4(0, 4'b0011, 1, 4'b0001, 1, 0, 4'b0001, 8'hA0);
`endif
      step4(0, 4'b0011, 1, 4'b0011, 1, 1, 4'b0010, 8'hA1);
      step4(0, 4'b0011, 1, 4'b0011, 1, 0, 4'b0001, 8'hA0);

      // requester drops valid while held: grant kept, valid follows the drop
      step4(0, 4'b0100, 0, 4'b1111, 1, 2, 4'b0000, 8'hA2);
      step4(0, 4'b0000, 0, 4'b1111, 0, 2, 4'b0000, 8'hA2);
      step4(0, 4'b0001, 1, 4'b1111, 0, 2, 4'b0000, 8'hA2);
      step4(0, 4'b0100, 1, 4'b1111, 1, 2, 4'b0100, 8'hA2);

      // N=3: wrap at 2, never 3
      step3(1, 3'b111, 1, 0, 0, 3'b000, 8'h00);
      step3(0, 3'b111, 1, 1, 0, 3'b001, 8'hB0);
      step3(0, 3'b111, 1, 1, 1, 3'b010, 8'hB1);
      step3(0, 3'b111, 1, 1, 2, 3'b100, 8'hB2);
      step3(0, 3'b111, 1, 1, 0, 3'b001, 8'hB0);
      step3(0, 3'b111, 1, 1, 1, 3'b010, 8'hB1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
